display_scan: RTL
=================

# display_scan

Multiplexed seven-segment display driver sitting directly downstream of the calculator core. It captures the (digit code, position) pairs the core emits into an internal digit buffer and continuously time-multiplexes the buffer onto a common-anode display, one digit at a time. A core status of error overrides the buffer with a fixed "Err" pattern without destroying the stored digits.

## Interface
- NUM_DIGITS, 8: number of display positions (1..16).
- SCAN_DIV, 50000: clock cycles each digit is lit, including its blanking cycle (min 2).

- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- wr_en  in  1  write strobe; captures data into buffer slot position.
- data  in  4  digit code: 0-9 decimal, 10 '-', 11 'E', 12 'r', 13-15 blank.
- position  in  4  buffer slot, 0 = rightmost digit.
- clear  in  1  synchronous clear of every buffer slot to blank (code 15).
- status  in  2  core status: 2'b00 idle, 2'b01 busy, 2'b10 result, 2'b11 error.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Digit buffer: NUM_DIGITS x 4-bit registers, all 15 (blank) on reset.
- Write: wr_en=1 and position < NUM_DIGITS -> slot[position] <= data next edge. position >= NUM_DIGITS: write dropped, no other effect.
- clear=1: all slots <= 15 next edge; clear wins over a simultaneous wr_en.
- Scanner: divider counter div 0..SCAN_DIV-1, digit index idx 0..NUM_DIGITS-1. div wraps to 0 after SCAN_DIV-1; idx increments on that wrap, wraps NUM_DIGITS-1 -> 0.
- Blanking: while div == 0, an = all ones, seg = 7'h7F (anti-ghosting). Otherwise an[idx]=0, others 1.
- Displayed code: status==2'b11 -> slot override: idx 2 'E', idx 1 'r', idx 0 'r', others blank; else slot[idx]. Buffer contents untouched by override; returning status to non-error restores stored digits.
- Decode (active-low seg): 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, '-' 3F, 'E' 06, 'r' 2F, blank 7F (hex).
- status 00/01/10 have no display effect.

## Timing
- Reset values: slots 15, div 0, idx 0, an all ones, seg 7'h7F.
- an and seg are registered: both reflect div/idx/buffer/status of the previous cycle (1-cycle latency). No combinational input-to-output path.
- Write visibility: slot updated at edge N; seen on seg at the first non-blanking cycle of that digit at or after edge N+1.
- status change is reflected on seg within 1 cycle when the affected digit is lit.
- Full frame period: NUM_DIGITS x SCAN_DIV cycles; each digit lit SCAN_DIV-1 cycles, dark 1.
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously); scan restarts at idx 0, div 0 after release.
- Write to the currently lit slot: seg changes on the following cycle, no blanking inserted.

## Test plan
- Reset: hold reset=0 mid-run -> an=all ones, seg=7F at once; after release first lit digit is idx 0 showing blank (7F).
- Write/scan (SCAN_DIV=4, NUM_DIGITS=8): write 1@0, 2@1, 9@7 -> an cycles FE,FD,...,7F with 1 all-high cycle between; seg 79 on idx 0, 24 on idx 1, 10 on idx 7, 7F elsewhere; frame = 32 cycles.
- Out-of-range and clear: write 5@8 -> no slot changes; wr_en with clear same cycle -> all slots blank.
- Error override: status=11 with digits stored -> idx 2/1/0 show 06/2F/2F, others 7F; status=10 -> original digits reappear unchanged.
- Live write: write 8 to slot currently lit -> seg becomes 00 next cycle, an unchanged.
- Wrap: run 3 full frames -> idx sequence 0..7 repeated exactly, no skipped or doubled digit.

Source files
------------

// File: rtl/display_scan.sv
// Multiplexed common-anode seven-segment driver: buffers (code, position) writes
// from the calculator core and scans them out one digit at a time.
module display_scan #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            data,
  input  logic [3:0]            position,
  input  logic                  clear,
  input  logic [1:0]            status,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [3:0] CODE_E     = 4'd11;
  localparam logic [3:0] CODE_R     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;
  localparam logic [1:0] ST_ERROR   = 2'b11;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  logic [3:0]            slot_q [NUM_DIGITS];
  logic [3:0]            slot_d [NUM_DIGITS];
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            code;
  logic [31:0]           idx_ext;

  // Buffer update; out-of-range positions match no slot and are dropped.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      slot_d[i] = slot_q[i];
      if (clear) begin
        slot_d[i] = CODE_BLANK;
      end else if (wr_en && (position == 4'(i))) begin
        slot_d[i] = data;
      end
    end
  end

  // Scan divider and digit index.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Select the code for the lit digit; error status substitutes "Err" without touching the buffer.
  always_comb begin
    code    = CODE_BLANK;
    idx_ext = 32'(idx_q);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        code = slot_q[i];
      end
    end
    if (status == ST_ERROR) begin
      case (idx_ext)
        32'd0:   code = CODE_R;
        32'd1:   code = CODE_R;
        32'd2:   code = CODE_E;
        default: code = CODE_BLANK;
      endcase
    end
  end

  // Segment decode and anode select; div == 0 is the anti-ghosting blank slot.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (div_q != '0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IDX_W'(i));
      end
      case (code)
        4'd0:    seg_d = 7'h40;
        4'd1:    seg_d = 7'h79;
        4'd2:    seg_d = 7'h24;
        4'd3:    seg_d = 7'h30;
        4'd4:    seg_d = 7'h19;
        4'd5:    seg_d = 7'h12;
        4'd6:    seg_d = 7'h02;
        4'd7:    seg_d = 7'h78;
        4'd8:    seg_d = 7'h00;
        4'd9:    seg_d = 7'h10;
        4'd10:   seg_d = 7'h3F;
        4'd11:   seg_d = 7'h06;
        4'd12:   seg_d = 7'h2F;
        default: seg_d = SEG_OFF;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot_q[i] <= CODE_BLANK;
      end
      div_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_OFF;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
